// File: rtl/game_sequencer_if.sv
// Signal bundle between the game sequencer and its surroundings.
// The master side drives the player/game inputs. The slave side is the sequencer.
interface game_sequencer_if;
  logic       start;
  logic       pause_btn;
  logic       kb_valid;
  logic [1:0] kb_dir;
  logic       btn_valid;
  logic [1:0] btn_dir;
  logic       lose;
  logic       win;
  logic       tick;
  logic [1:0] dir;
  logic [1:0] state;
  logic       restart;
  logic [1:0] q_count;

  modport master (
    output start, pause_btn, kb_valid, kb_dir, btn_valid, btn_dir, lose, win,
    input  tick, dir, state, restart, q_count
  );

  modport slave (
    input  start, pause_btn, kb_valid, kb_dir, btn_valid, btn_dir, lose, win,
    output tick, dir, state, restart, q_count
  );
endinterface

// File: rtl/game_sequencer.sv
// Snake game sequencer. It provides the game-step tick timer, run/pause/over control,
// and a two-deep queue of direction turns that are applied on each tick.
//
// state | meaning
// IDLE  | after reset; the timer is held and requests are ignored
// PLAY  | the timer runs; each tick applies the next queued turn
// PAUSE | the timer is frozen and the remaining step time is kept
// OVER  | the game has ended; only start leaves this state
module game_sequencer #(
  parameter logic [26:0] TICK_DIV = 27'd10600000
) (
  input logic             clk,
  input logic             rst,
  game_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [26:0] r_cnt, w_cnt_nxt;
  logic        r_tick, w_tick_nxt;
  logic        r_restart, w_restart_nxt;
  logic [1:0]  r_dir, w_dir_nxt;
  logic [1:0]  r_q0, w_q0_nxt;        // queue head
  logic [1:0]  r_q1, w_q1_nxt;        // second entry
  logic [1:0]  r_qcnt, w_qcnt_nxt;
  logic        r_pause_d;

  logic        w_pause_rise;
  logic        w_req_valid;
  logic [1:0]  w_req_dir;
  logic [1:0]  w_tail;
  logic [1:0]  w_ref;
  logic        w_push;
  logic        w_pop;

  assign w_pause_rise = bus.pause_btn & ~r_pause_d;

  // When both sources make a request in the same cycle, the keyboard request wins.
  assign w_req_valid = bus.kb_valid | bus.btn_valid;
  assign w_req_dir   = bus.kb_valid ? bus.kb_dir : bus.btn_dir;

  // A new turn is filtered against the last queued turn, or against dir when the queue is empty.
  assign w_tail = (r_qcnt == 2'd2) ? r_q1 : r_q0;
  assign w_ref  = (r_qcnt != 2'd0) ? w_tail : r_dir;
  assign w_push = (r_state == ST_PLAY) && w_req_valid &&
                  (w_req_dir != w_ref) && (w_req_dir != (w_ref ^ 2'b10));

  // Next-state logic for the mode, the step timer and the turn queue.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_tick_nxt    = 1'b0;
    w_restart_nxt = 1'b0;
    w_dir_nxt     = r_dir;
    w_q0_nxt      = r_q0;
    w_q1_nxt      = r_q1;
    w_qcnt_nxt    = r_qcnt;
    w_pop         = 1'b0;

    if (bus.start) begin
      w_state_nxt   = ST_PLAY;
      w_restart_nxt = 1'b1;
      w_dir_nxt     = 2'd0;
      w_qcnt_nxt    = 2'd0;
      w_cnt_nxt     = 27'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_cnt_nxt = 27'd0;
        end
        ST_PLAY: begin
          if (bus.lose || bus.win) begin
            w_state_nxt = ST_OVER;
          end else begin
            // A pause edge freezes the timer on that edge, so no step time is lost.
            if (w_pause_rise) begin
              w_state_nxt = ST_PAUSE;
            end else if (r_cnt == TICK_DIV - 27'd1) begin
              w_cnt_nxt  = 27'd0;
              w_tick_nxt = 1'b1;
              w_pop      = (r_qcnt != 2'd0);
            end else begin
              w_cnt_nxt = r_cnt + 27'd1;
            end

            if (w_pop) begin
              w_dir_nxt = r_q0;
            end

            case ({w_push, w_pop})
              2'b01: begin
                w_q0_nxt   = r_q1;
                w_qcnt_nxt = r_qcnt - 2'd1;
              end
              2'b10: begin
                if (r_qcnt == 2'd0) begin
                  w_q0_nxt   = w_req_dir;
                  w_qcnt_nxt = 2'd1;
                end else if (r_qcnt == 2'd1) begin
                  w_q1_nxt   = w_req_dir;
                  w_qcnt_nxt = 2'd2;
                end
              end
              2'b11: begin
                // The pop frees a slot on the same edge, so the push always succeeds.
                if (r_qcnt == 2'd1) begin
                  w_q0_nxt = w_req_dir;
                end else begin
                  w_q0_nxt = r_q1;
                  w_q1_nxt = w_req_dir;
                end
              end
              default: ;
            endcase
          end
        end
        ST_PAUSE: begin
          if (w_pause_rise) begin
            w_state_nxt = ST_PLAY;
          end
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 27'd0;
      r_tick    <= 1'b0;
      r_restart <= 1'b0;
      r_dir     <= 2'd0;
      r_q0      <= 2'd0;
      r_q1      <= 2'd0;
      r_qcnt    <= 2'd0;
      r_pause_d <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tick    <= w_tick_nxt;
      r_restart <= w_restart_nxt;
      r_dir     <= w_dir_nxt;
      r_q0      <= w_q0_nxt;
      r_q1      <= w_q1_nxt;
      r_qcnt    <= w_qcnt_nxt;
      r_pause_d <= bus.pause_btn;
    end
  end

  assign bus.tick    = r_tick;
  assign bus.dir     = r_dir;
  assign bus.state   = r_state;
  assign bus.restart = r_restart;
  assign bus.q_count = r_qcnt;

endmodule
